// File: rtl/fc_pkg.sv
// Shared types and default-size constants for the FC operand fetch sequencer.
package fc_pkg;

    typedef enum logic [2:0] {
        BUF_X  = 3'd0,
        BUF_W1 = 3'd1,
        BUF_B1 = 3'd2,
        BUF_W2 = 3'd3,
        BUF_B2 = 3'd4
    } buf_sel_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_F_X   = 3'd1,
        S_F_W1  = 3'd2,
        S_F_B1  = 3'd3,
        S_F_W2  = 3'd4,
        S_F_B2  = 3'd5,
        S_DRAIN = 3'd6
    } state_t;

    localparam int DEF_IP1 = 128;
    localparam int DEF_OP1 = 84;
    localparam int DEF_IP2 = 84;
    localparam int DEF_OP2 = 10;

    localparam int LEN_X  = DEF_IP1;
    localparam int LEN_W1 = DEF_IP1 * DEF_OP1;
    localparam int LEN_B1 = DEF_OP1;
    localparam int LEN_W2 = DEF_IP2 * DEF_OP2;
    localparam int LEN_B2 = DEF_OP2;
    localparam int TOTAL_WORDS = LEN_X + LEN_W1 + LEN_B1 + LEN_W2 + LEN_B2;

    function automatic int total_words(input int ip1, input int op1, input int ip2, input int op2);
        return ip1 + ip1 * op1 + op1 + ip2 * op2 + op2;
    endfunction

endpackage

// File: rtl/fc_idx_counter.sv
// Row/column walker for one buffer region; wraps to (0,0) after the last element.
module fc_idx_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       step,
    input  logic [7:0] row_limit,
    input  logic [7:0] col_limit,
    output logic [7:0] row,
    output logic [7:0] col,
    output logic       last
);

    logic [7:0] row_reg;
    logic [7:0] col_reg;
    logic       col_end;

    assign col_end = (col_reg == col_limit - 8'd1);
    assign last    = col_end && (row_reg == row_limit - 8'd1);
    assign row     = row_reg;
    assign col     = col_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (clear) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (step) begin
            if (last) begin
                row_reg <= '0;
                col_reg <= '0;
            end else if (col_end) begin
                col_reg <= '0;
                row_reg <= row_reg + 8'd1;
            end else begin
                col_reg <= col_reg + 8'd1;
            end
        end
    end

endmodule

// File: rtl/fc_fetch_ctrl.sv
// Streams X, W1, B1, W2, B2 from one contiguous RAM image into the FC operand
// buffers, then pulses enFC once every operand is resident.
module fc_fetch_ctrl #(
    parameter int WORD_SIZE      = 16,
    parameter int ADDRESS_SIZE   = 16,
    parameter int IP_LAYER1_SIZE = 128,
    parameter int OP_LAYER1_SIZE = 84,
    parameter int IP_LAYER2_SIZE = 84,
    parameter int OP_LAYER2_SIZE = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fetch_from_ram,
    input  logic [ADDRESS_SIZE-1:0] base_addr,
    output logic                    ram_rd_en,
    output logic [ADDRESS_SIZE-1:0] ram_addr,
    input  logic                    ram_gnt,
    input  logic [WORD_SIZE-1:0]    ram_rd_data,
    output logic                    buf_wr_en,
    output logic [2:0]              buf_sel,
    output logic [7:0]              buf_row,
    output logic [7:0]              buf_col,
    output logic [WORD_SIZE-1:0]    buf_wr_data,
    output logic                    busy,
    output logic                    enFC
);
    import fc_pkg::*;

    localparam logic [7:0] L_IP1 = 8'(IP_LAYER1_SIZE);
    localparam logic [7:0] L_OP1 = 8'(OP_LAYER1_SIZE);
    localparam logic [7:0] L_IP2 = 8'(IP_LAYER2_SIZE);
    localparam logic [7:0] L_OP2 = 8'(OP_LAYER2_SIZE);

    state_t                  state_reg, state_next;
    logic [ADDRESS_SIZE-1:0] addr_reg;
    logic                    wr_en_reg;
    buf_sel_t                sel_reg;
    logic [7:0]              row_reg, col_reg;
    logic                    enfc_reg, busy_reg;

    logic       fetching, accept, start;
    logic [7:0] row_limit, col_limit, idx_row, idx_col;
    logic       idx_last;
    buf_sel_t   cur_sel;

    assign fetching = (state_reg == S_F_X) || (state_reg == S_F_W1) || (state_reg == S_F_B1) ||
                      (state_reg == S_F_W2) || (state_reg == S_F_B2);
    assign accept   = fetching && ram_gnt;
    // The enFC cycle is still part of the busy window, so a start there is dropped.
    assign start    = (state_reg == S_IDLE) && fetch_from_ram && !enfc_reg;

    fc_idx_counter u_idx (
        .clk       (clk),
        .reset     (reset),
        .clear     (start),
        .step      (accept),
        .row_limit (row_limit),
        .col_limit (col_limit),
        .row       (idx_row),
        .col       (idx_col),
        .last      (idx_last)
    );

    always_comb begin
        row_limit = 8'd1;
        col_limit = 8'd1;
        cur_sel   = BUF_X;
        case (state_reg)
            S_F_X:   begin col_limit = L_IP1; cur_sel = BUF_X; end
            S_F_W1:  begin row_limit = L_OP1; col_limit = L_IP1; cur_sel = BUF_W1; end
            S_F_B1:  begin col_limit = L_OP1; cur_sel = BUF_B1; end
            S_F_W2:  begin row_limit = L_OP2; col_limit = L_IP2; cur_sel = BUF_W2; end
            S_F_B2:  begin col_limit = L_OP2; cur_sel = BUF_B2; end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_F_X;
            S_F_X:   if (accept && idx_last) state_next = S_F_W1;
            S_F_W1:  if (accept && idx_last) state_next = S_F_B1;
            S_F_B1:  if (accept && idx_last) state_next = S_F_W2;
            S_F_W2:  if (accept && idx_last) state_next = S_F_B2;
            S_F_B2:  if (accept && idx_last) state_next = S_DRAIN;
            // The final write always lands in the first DRAIN cycle.
            S_DRAIN: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            addr_reg  <= '0;
            wr_en_reg <= 1'b0;
            sel_reg   <= BUF_X;
            row_reg   <= '0;
            col_reg   <= '0;
            enfc_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start) begin
                addr_reg <= base_addr;
            end else if (accept) begin
                addr_reg <= addr_reg + 1'b1;
            end
            wr_en_reg <= accept;
            if (accept) begin
                sel_reg <= cur_sel;
                row_reg <= idx_row;
                col_reg <= idx_col;
            end
            enfc_reg <= (state_reg == S_DRAIN);
            busy_reg <= (state_next != S_IDLE) || (state_reg == S_DRAIN);
        end
    end

    assign ram_rd_en   = fetching;
    assign ram_addr    = addr_reg;
    assign buf_wr_en   = wr_en_reg;
    assign buf_sel     = sel_reg;
    assign buf_row     = row_reg;
    assign buf_col     = col_reg;
    // RAM data is already registered on its side and arrives together with the strobe;
    // gating keeps the data bus quiet outside write cycles and in reset.
    assign buf_wr_data = wr_en_reg ? ram_rd_data : '0;
    assign busy        = busy_reg;
    assign enFC        = enfc_reg;

endmodule
